// File: rtl/tow_pkg.sv
// Shared definitions for the tug-of-war game: FSM states, scorer result words
// and the LFSR feedback mask.
package tow_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DELAY,
        LIGHT,
        HOLD,
        DONE
    } state_t;

    localparam logic [6:0] SCORE_WL  = 7'b1110000;
    localparam logic [6:0] SCORE_WR  = 7'b0000111;
    localparam logic [6:0] SCORE_ERR = 7'b1010101;

    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic game_over(input logic [6:0] s);
        return (s == SCORE_WL) || (s == SCORE_WR) || (s == SCORE_ERR);
    endfunction

endpackage

// File: rtl/round_ctrl_if.sv
// Button/score inputs and round-result outputs of the round controller.
interface round_ctrl_if;
    logic       pbl;
    logic       pbr;
    logic [6:0] score;
    logic       winrnd;
    logic       right;
    logic       leds_on;

    modport master (output pbl, pbr, score, input winrnd, right, leds_on);
    modport slave  (input pbl, pbr, score, output winrnd, right, leds_on);
endinterface

// File: rtl/tow_lfsr.sv
// 16-bit Galois LFSR with reset seed and advance enable.
module tow_lfsr
    import tow_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] lfsr
);

    always_ff @(posedge clk) begin
        if (!rst)
            lfsr <= SEED;
        else if (en)
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : '0);
    end

endmodule

// File: rtl/round_ctrl.sv
// Tug-of-war round controller: random lights-off delay, first-push detection.
// Optional lights-on timeout enabled by defining ROUND_TIMEOUT_EN.
module round_ctrl
    import tow_pkg::*;
#(
    parameter int unsigned    DELAY_MIN      = 2048,
    parameter int unsigned    DELAY_W        = 12,
    parameter int unsigned    HOLD_CYCLES    = 4096,
    parameter logic [15:0]    LFSR_SEED      = 16'hACE1,
    parameter int unsigned    TIMEOUT_CYCLES = 65535
) (
    input  logic         clk,
    input  logic         rst,
    round_ctrl_if.slave  bus
);

    localparam int unsigned DELAY_MAX = DELAY_MIN + (1 << DELAY_W) - 1;
    localparam int unsigned CNT_MAX_A = (DELAY_MAX > HOLD_CYCLES) ? DELAY_MAX : HOLD_CYCLES;
    localparam int unsigned CNT_MAX   = (CNT_MAX_A > TIMEOUT_CYCLES) ? CNT_MAX_A : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      lfsr;
    logic             prio;
    logic             pbl_q;
    logic             pbr_q;
    logic             push_l;
    logic             push_r;
    logic             push_any;
    logic             win_r;
    logic             unused_lfsr;

    tow_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .en   (1'b1),
        .lfsr (lfsr)
    );

    assign unused_lfsr = ^lfsr;

    always_comb begin
        push_l   = bus.pbl & ~pbl_q;
        push_r   = bus.pbr & ~pbr_q;
        push_any = push_l | push_r;
        // A tie goes to whoever holds priority; otherwise the lone pusher wins
        win_r    = (push_l & push_r) ? prio : push_r;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            prio        <= 1'b0;
            pbl_q       <= 1'b0;
            pbr_q       <= 1'b0;
            bus.winrnd  <= 1'b0;
            bus.right   <= 1'b0;
            bus.leds_on <= 1'b0;
        end else begin
            pbl_q      <= bus.pbl;
            pbr_q      <= bus.pbr;
            bus.winrnd <= 1'b0;
            case (state)
                IDLE: begin
                    bus.leds_on <= 1'b0;
                    if (!bus.pbl && !bus.pbr) begin
                        cnt   <= CNT_W'(DELAY_MIN) + CNT_W'(lfsr[DELAY_W-1:0]);
                        state <= DELAY;
                    end
                end
                DELAY, LIGHT: begin
                    // leds_on is left as-is on a push so it records jump-the-light vs. fair win
                    if (push_any) begin
                        bus.winrnd <= 1'b1;
                        bus.right  <= win_r;
                        if (push_l && push_r)
                            prio <= ~prio;
                        cnt   <= HOLD_LOAD;
                        state <= HOLD;
                    end else if (state == DELAY) begin
                        if (cnt == '0) begin
                            bus.leds_on <= 1'b1;
                            cnt         <= CNT_W'(TIMEOUT_CYCLES - 1);
                            state       <= LIGHT;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
`ifdef ROUND_TIMEOUT_EN
                    else if (cnt == '0) begin
                        bus.leds_on <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
`endif
                end
                HOLD: begin
                    if (cnt == '0) begin
                        bus.leds_on <= 1'b0;
                        state       <= game_over(bus.score) ? DONE : IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    bus.leds_on <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_round_ctrl.sv
// Scoreboard bench for round_ctrl: directed rounds, expected results queued at push time.
module tb_round_ctrl;

    logic clk;
    logic rst;
    int unsigned tests;
    int unsigned fails;
    logic [1:0]  exp_q[$];  // {right, leds_on}

    round_ctrl_if rif();

    round_ctrl #(
        .DELAY_MIN      (8),
        .DELAY_W        (2),
        .HOLD_CYCLES    (16),
        .LFSR_SEED      (16'h0001),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (rif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every winrnd pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (rif.winrnd === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected: got winrnd right=%0b leds=%0b expected none",
                         rif.right, rif.leds_on);
            end else begin
                logic [1:0] e;
                e = exp_q.pop_front();
                if ({rif.right, rif.leds_on} !== e) begin
                    fails++;
                    $display("FAIL sb_result: got right/leds=%0b%0b expected %0b%0b",
                             rif.right, rif.leds_on, e[1], e[0]);
                end
            end
        end
    end

    task automatic wait_leds(input logic val, input int unsigned budget, input string name,
                             output int unsigned n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (rif.leds_on !== val && n < budget);
        check(name, rif.leds_on, val);
    endtask

    // Drive a push, expect winrnd exactly one cycle later and only then
    task automatic push(input logic l, input logic r, input logic exp_r, input logic exp_l);
        rif.pbl = l;
        rif.pbr = r;
        exp_q.push_back({exp_r, exp_l});
        @(posedge clk);
        @(negedge clk);
        check("push_latency", rif.winrnd, 1'b1);
        rif.pbl = 1'b0;
        rif.pbr = 1'b0;
        @(negedge clk);
        check("push_single", rif.winrnd, 1'b0);
    endtask

    task automatic count_lit(input int unsigned cycles, output int unsigned lit);
        lit = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (rif.leds_on !== 1'b0) lit++;
        end
    endtask

    initial begin
        int unsigned n;
        int unsigned lit;
        tests = 0;
        fails = 0;
        rst = 1'b0;
        rif.pbl = 1'b0;
        rif.pbr = 1'b0;
        rif.score = 7'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_winrnd", rif.winrnd, 1'b0);
        check("rst_right", rif.right, 1'b0);
        check("rst_leds", rif.leds_on, 1'b0);

        // First load uses seed 1 -> delay 8+1; 1 load edge + 9 decrements + zero-read edge
        rst = 1'b1;
        wait_leds(1'b1, 100, "delay_rise", n);
        check("delay_len", n, 11);

        // Fair win by right in LIGHT, then HOLD keeps lamps on for 16 cycles
        push(1'b0, 1'b1, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        check("hold_leds", rif.leds_on, 1'b1);
        wait_leds(1'b0, 100, "hold_fall", n);
        check("hold_len", n + 3, 15);

        // Jump-the-light by left in DELAY: lamps stay dark
        repeat (3) @(negedge clk);
        push(1'b1, 1'b0, 1'b0, 1'b0);
        count_lit(18, lit);
        check("jump_dark", lit, 0);

        // Two ties in LIGHT: priority starts left, then flips to right
        wait_leds(1'b1, 100, "tie1_rise", n);
        push(1'b1, 1'b1, 1'b0, 1'b1);
        wait_leds(1'b0, 100, "tie1_fall", n);
        wait_leds(1'b1, 100, "tie2_rise", n);
        push(1'b1, 1'b1, 1'b1, 1'b1);
        rif.score = 7'b0000111;
        wait_leds(1'b0, 100, "win_fall", n);

        // DONE: further pushes are ignored, lamps stay off
        for (int i = 0; i < 10; i++) begin
            rif.pbl = i[0];
            rif.pbr = ~i[0];
            @(negedge clk);
            rif.pbl = 1'b0;
            rif.pbr = 1'b0;
            repeat (3) @(negedge clk);
        end
        count_lit(20, lit);
        check("done_dark", lit, 0);

        // One reset cycle with left held down: back to IDLE with outputs cleared
        rif.pbl = 1'b1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        rif.score = 7'd0;
        check("rst2_winrnd", rif.winrnd, 1'b0);
        check("rst2_right", rif.right, 1'b0);
        check("rst2_leds", rif.leds_on, 1'b0);
        count_lit(30, lit);
        check("held_dark", lit, 0);
        rif.pbl = 1'b0;
        wait_leds(1'b1, 100, "release_rise", n);

        // Reset in the same cycle as a push: no winrnd, outputs cleared
        rif.pbr = 1'b1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_winrnd", rif.winrnd, 1'b0);
        check("midrst_leds", rif.leds_on, 1'b0);
        rst = 1'b1;
        rif.pbr = 1'b0;
        wait_leds(1'b1, 100, "post_rst_rise", n);

`ifdef ROUND_TIMEOUT_EN
        wait_leds(1'b0, 100, "timeout_fall", n);
        check("timeout_len", n, 16);
        wait_leds(1'b1, 100, "timeout_next_rise", n);
`else
        count_lit(100, lit);
        check("light_waits", lit, 100);
`endif

        repeat (2) @(negedge clk);
        check("sb_drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
